// File: rtl/uart_rs232_rx.sv
// uart_rs232_rx: 8N1 serial receiver with an NBits-wide payload (5..8).
// Rx is synchronized into the Clk domain and sampled at mid-bit using the
// shared OSR x baud Tick enable. A good frame gives a one-cycle RxDone.
// A low stop bit gives a one-cycle FrameErr, and the receiver then waits
// for the line to return high before it arms again.
module uart_rs232_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OSR         = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx,
  input  logic       Tick,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int TCW = $clog2(OSR);
  localparam logic [TCW-1:0] TC_MID = TCW'(OSR/2 - 1);
  localparam logic [TCW-1:0] TC_END = TCW'(OSR - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rs;
  logic [TCW-1:0]   tc;
  logic [2:0]       bit_cnt;
  logic [3:0]       nbits_q;
  logic [3:0]       nbits_clamp;
  logic [7:0]       shreg;

  // Input synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
  end

  assign rs          = sync_q[SYNC_STAGES-1];
  assign nbits_clamp = (NBits >= 4'd5 && NBits <= 4'd8) ? NBits : 4'd8;

  // Frame FSM: counts ticks within a bit and samples at the bit centre.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      tc       <= '0;
      bit_cnt  <= '0;
      nbits_q  <= 4'd8;
      shreg    <= '0;
      RxData   <= '0;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      if (Tick) begin
        case (state)
          S_IDLE: begin
            if (!rs) begin
              state <= S_START;
              tc    <= '0;
              Busy  <= 1'b1;
            end
          end
          S_START: begin
            if (tc == TC_MID) begin
              // Still low at mid-start: a real start bit, not a glitch.
              if (!rs) begin
                nbits_q <= nbits_clamp;
                shreg   <= '0;
                bit_cnt <= '0;
                tc      <= '0;
                state   <= S_DATA;
              end else begin
                state <= S_IDLE;
                Busy  <= 1'b0;
              end
            end else begin
              tc <= tc + TCW'(1);
            end
          end
          S_DATA: begin
            if (tc == TC_END) begin
              shreg[bit_cnt] <= rs;
              bit_cnt        <= bit_cnt + 3'd1;
              tc             <= '0;
              if (bit_cnt == 3'(nbits_q - 4'd1)) state <= S_STOP;
            end else begin
              tc <= tc + TCW'(1);
            end
          end
          S_STOP: begin
            if (tc == TC_END) begin
              tc <= '0;
              // Going idle at mid-stop leaves half a bit to catch the next start.
              if (rs) begin
                RxData <= shreg;
                RxDone <= 1'b1;
                state  <= S_IDLE;
                Busy   <= 1'b0;
              end else begin
                FrameErr <= 1'b1;
                state    <= S_BREAK;
              end
            end else begin
              tc <= tc + TCW'(1);
            end
          end
          S_BREAK: begin
            // Held-low line: only re-arm once it is seen high again.
            if (rs) begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rs232_rx.sv
// Bench for uart_rs232_rx: a task-driven serial source aligned to Tick,
// a scoreboard of expected words, and a negedge monitor that checks strobes.
module tb_uart_rs232_rx;
  localparam int OSR = 16;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic       Tick = 1'b0;
  logic [3:0] NBits = 4'd8;
  logic [7:0] RxData;
  logic       RxDone, FrameErr, Busy;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int fe_cnt   = 0;
  int tick_div = 4;
  int tick_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rs232_rx #(.SYNC_STAGES(2), .OSR(OSR)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .Tick(Tick), .NBits(NBits),
    .RxData(RxData), .RxDone(RxDone), .FrameErr(FrameErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Tick generator: one pulse every tick_div clocks (tick_div=1 holds it high).
  always @(posedge Clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt <= 0;
      Tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      Tick     <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pop the scoreboard on RxDone and count frame errors.
  always @(negedge Clk) begin
    if (RxDone) begin
      done_cnt++;
      chk("fe_with_done", FrameErr, 0);
      chk("exp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rx_data", RxData, exp_q.pop_front());
    end
    if (FrameErr) fe_cnt++;
  end

  task automatic wait_tick();
    do @(posedge Clk); while (Tick !== 1'b1);
    #1;
  endtask

  task automatic send_bit(input logic b, input int nticks = OSR);
    Rx = b;
    repeat (nticks) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic stop);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) if (i < nb) e[i] = d[i];
    if (stop) exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge Clk);
    chk("rst_rxdata", RxData, 8'h00);
    chk("rst_rxdone", RxDone, 0);
    chk("rst_frameerr", FrameErr, 0);
    chk("rst_busy", Busy, 0);
    @(negedge Clk); Rst_n = 1'b1;
    send_bit(1'b1);

    // Back-to-back frames, Tick every 4 clocks.
    NBits = 4'd8;
    send_frame(8'hA5, 8, 1'b1);
    send_frame(8'h3C, 8, 1'b1);
    send_bit(1'b1);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_fe_cnt", fe_cnt, 0);

    // 5-bit payload; upper bits must come out zero.
    NBits = 4'd5;
    send_frame(8'b10110, 5, 1'b1);
    send_bit(1'b1);
    chk("nb5_done_cnt", done_cnt, 3);
    chk("nb5_rxdata", RxData, 8'h16);

    // Start glitch of 5 ticks.
    NBits = 4'd8;
    send_bit(1'b0, 5);
    chk("glitch_busy_hi", Busy, 1);
    send_bit(1'b1, 7);
    chk("glitch_busy_lo", Busy, 0);
    send_bit(1'b1);
    chk("glitch_done_cnt", done_cnt, 3);
    chk("glitch_fe_cnt", fe_cnt, 0);

    // Framing error, then a held-low line, then a good frame.
    send_frame(8'h55, 8, 1'b0);
    send_bit(1'b0, 3*OSR);
    chk("fe_cnt", fe_cnt, 1);
    chk("fe_rx_hold", RxData, 8'h16);
    chk("fe_break_busy", Busy, 1);
    chk("fe_no_retrig", done_cnt, 3);
    send_bit(1'b1);
    send_frame(8'h0F, 8, 1'b1);
    send_bit(1'b1);
    chk("fe_recover_done", done_cnt, 4);
    chk("fe_recover_data", RxData, 8'h0F);

    // Reset during bit 3 of a frame.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1, 5);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("mid_rst_rxdata", RxData, 8'h00);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", RxDone, 0);
    chk("mid_rst_fe", FrameErr, 0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    send_bit(1'b1);
    send_frame(8'h81, 8, 1'b1);
    send_bit(1'b1);
    chk("post_rst_done", done_cnt, 5);
    chk("post_rst_data", RxData, 8'h81);

    // Full byte sweep with Tick held high.
    tick_div = 2;
    send_bit(1'b1);
    tick_div = 1;
    send_bit(1'b1);
    for (int v = 0; v < 256; v++) send_frame(8'(v), 8, 1'b1);
    send_bit(1'b1);
    chk("sweep_done_cnt", done_cnt, 261);
    chk("sweep_fe_cnt", fe_cnt, 1);
    chk("sweep_last", RxData, 8'hFF);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rs232_rx.md
Name: uart_rs232_rx

Overview:
Serial RS-232 receiver paired with the team's existing UART transmitter. It samples the asynchronous Rx line using the shared 16x-baud Tick pulse and assembles an 8N1 frame with an NBits-bit payload. It presents the received word with a one-cycle RxDone strobe and flags framing errors. Everything runs in the Clk domain; Tick is a clock enable, never a clock.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the Rx input synchronizer (minimum 2).
OSR, 16, Tick pulses per bit period (must be even, 4..16).

Ports:
Clk  input  1  system clock; every register is clocked on its rising edge.
Rst_n  input  1  asynchronous, active-low reset.
Rx  input  1  serial line, idle high, asynchronous to Clk.
Tick  input  1  single-Clk-cycle pulse at OSR x baud rate; the same generator that drives the transmitter.
NBits  input  4  payload length; legal values 5..8. Any other value is treated as 8. Sampled once per frame at start-bit confirmation.
RxData  output  8  last good word, LSB first on the wire. RxData[i] holds bit i; bits at NBits and above are 0.
RxDone  output  1  one-Clk pulse when RxData has been updated with a good frame.
FrameErr  output  1  one-Clk pulse when the stop bit is sampled low.
Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, async on Rst_n low: state=IDLE, RxData=0, RxDone=0, FrameErr=0, Busy=0, tick counter=0, bit counter=0. Synchronizer flops reset to 1 (line idle). Reset mid-frame abandons the frame and produces no strobe.
- Rx passes through SYNC_STAGES flops. All decisions use the synchronized value rs.
- The tick counter tc and all sampling advance only in Clk cycles where Tick=1.
- IDLE: when rs=0 on a Tick, go to START and set tc=0.
- START: on each Tick, increment tc. When tc reaches OSR/2-1, the bit is at mid-start. If rs=0 there, latch NBits (clamped), clear the shift register and bit counter, set tc=0, and go to DATA. If rs=1 there, the low level was a glitch; return to IDLE with no strobe.
- DATA: on each Tick, increment tc. When tc=OSR-1 (mid-bit), store rs into bit[bit_cnt], increment bit_cnt, and set tc=0. After bit NBits-1 is stored, go to STOP.
- STOP: when tc=OSR-1 (mid stop bit), sample rs.
  - rs=1: RxData takes the assembled word (upper bits zeroed), RxDone=1 for exactly one Clk cycle (the cycle after the sampling Tick), then IDLE.
  - rs=0: RxData is unchanged, FrameErr=1 for one Clk, then go to BREAK.
- BREAK: wait until rs=1 on a Tick, then go to IDLE. This prevents a held-low line from retriggering continuously.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving half a bit later is caught without loss.
- RxDone and FrameErr are never high in the same cycle. RxData holds its value between strobes.
- NBits changing mid-frame has no effect on the current frame.
- Tick held high continuously is legal: every Clk cycle counts as a tick.
- Latency: RxDone rises 1 Clk after the Tick at stop-bit mid, which is (1 + NBits + 0.5) bit periods after the start falling edge plus SYNC_STAGES Clk cycles.

Test Plan:
- Tick every 4 Clk, NBits=8, send 0xA5 then 0x3C back-to-back with a 1-bit stop and no gap. Required: two RxDone pulses with RxData=0xA5 then 0x3C, and FrameErr never set.
- NBits=5, send payload 5'b10110. Required: RxData=8'h16, upper 3 bits 0, RxDone once.
- Drive a Rx low pulse of 5 ticks then high. Required: return to IDLE, no RxDone, no FrameErr, Busy low again within 1 Clk of the mid-start Tick.
- Send 0x55 with the stop bit forced low, then hold the line low for 3 bit periods, then release and send 0x0F. Required: FrameErr single pulse, RxData unchanged, no retrigger while low, then RxDone with RxData=0x0F.
- Assert Rst_n low during bit 3 of a frame, release, then send 0x81. Required: all outputs 0 during reset, no strobe for the broken frame, then RxDone with RxData=0x81.
- Loopback with uart_rs232_tx sharing Tick, NBits=8, sweep all 256 values. Required: every RxData equals the transmitted TxData, with 256 RxDone pulses and 0 FrameErr.
